lcd_rom_sequencer: RTL and testbench

- Reader/consumer end of the LCD message ROM interface.
- After reset, runs the HD44780 power-up and init sequence. On each start request it walks the ROM address space from 0, fetches 9-bit entries ({rs, byte}) and drives the 8-bit parallel LCD bus with correct E-strobe timing.
- Sits between the message ROM and the LCD pins.

---
 rtl/lcd_rom_sequencer.sv | 118 +++++++++++
 tb/tb_lcd_rom_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/lcd_rom_sequencer.sv
// lcd_rom_sequencer: HD44780 power-up/init, then streams {rs,byte} entries from rom_addr/rom_data onto lcd_rs/lcd_rw/lcd_e/lcd_db; start requests a message, busy/done report progress
module lcd_rom_sequencer #(
  parameter int ADDR_W = 6,
  parameter int ROM_DEPTH = 32,
  parameter int POWERUP_CYCLES = 750000,
  parameter int SETUP_CYCLES = 2,
  parameter int E_HIGH_CYCLES = 12,
  parameter int CMD_WAIT_CYCLES = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [8:0]        rom_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_e,
  output logic [7:0]        lcd_db,
  output logic              busy,
  output logic              done
);
  localparam int MAX_CYC = POWERUP_CYCLES > CLEAR_WAIT_CYCLES ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMD_LD = CNT_W'(CMD_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROM_DEPTH - 1);
  typedef enum logic [2:0] {PWRUP, INIT, IDLE, FETCH, SETUP, EHIGH, WAIT} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] addr_n;
  logic rs_n, in_init, init_n, pending, pend_n, cnt_z, clear_cmd;
  logic [7:0] db_n, init_cmd;
  logic [1:0] idx, idx_n;
  assign init_cmd = idx == 2'd0 ? 8'h38 : idx == 2'd1 ? 8'h0C : idx == 2'd2 ? 8'h06 : 8'h01;
  assign clear_cmd = !lcd_rs && lcd_db[7:2] == 6'd0 && lcd_db[1:0] != 2'd0;
  assign cnt_z = cnt == '0;
  assign lcd_rw = 1'b0;
  assign lcd_e = state == EHIGH;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PWRUP;
      cnt <= PWRUP_LD;
      rom_addr <= '0;
      lcd_rs <= 1'b0;
      lcd_db <= '0;
      idx <= '0;
      in_init <= 1'b1;
      pending <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      rom_addr <= addr_n;
      lcd_rs <= rs_n;
      lcd_db <= db_n;
      idx <= idx_n;
      in_init <= init_n;
      pending <= pend_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt - CNT_W'(1);
    addr_n = rom_addr;
    rs_n = lcd_rs;
    db_n = lcd_db;
    idx_n = idx;
    init_n = in_init;
    pend_n = pending | (start & in_init);
    done = 1'b0;
    case (state)
      PWRUP: state_n = cnt_z ? INIT : PWRUP;
      INIT: begin
        rs_n = 1'b0;
        db_n = init_cmd;
        state_n = SETUP;
        cnt_n = SETUP_LD;
      end
      IDLE: if (start || pending) begin
        state_n = FETCH;
        addr_n = '0;
        pend_n = 1'b0;
      end
      FETCH: begin
        rs_n = rom_data[8];
        db_n = rom_data[7:0];
        state_n = SETUP;
        cnt_n = SETUP_LD;
      end
      SETUP: if (cnt_z) begin
        state_n = EHIGH;
        cnt_n = EHIGH_LD;
      end
      EHIGH: if (cnt_z) begin
        state_n = WAIT;
        cnt_n = clear_cmd ? CLEAR_LD : CMD_LD;
      end
      WAIT: if (cnt_z) begin
        if (in_init) begin
          state_n = idx == 2'd3 ? IDLE : INIT;
          init_n = idx != 2'd3;
          idx_n = idx + 2'd1;
        end else if (rom_addr == LAST) begin
          done = 1'b1;
          state_n = IDLE;
        end else begin
          addr_n = rom_addr + ADDR_W'(1);
          state_n = FETCH;
        end
      end
      default: state_n = PWRUP;
    endcase
  end
endmodule

// File: tb/tb_lcd_rom_sequencer.sv
// tb_lcd_rom_sequencer: directed bench with an expected-strobe scoreboard for lcd_rom_sequencer
module tb_lcd_rom_sequencer;
  localparam int EH = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0] rom_addr;
  logic [8:0] rom_data;
  logic lcd_rs, lcd_rw, lcd_e, busy, done;
  logic [7:0] lcd_db;
  logic [8:0] rom [4];
  int cyc = 0, checks = 0, errors = 0, last_rise = 0, done_cnt = 0, done_cyc = 0, drun = 0, hi_w = 0;
  int s, d0, r;
  logic prev_e = 1'b0, prev_done = 1'b0;
  logic [8:0] held;
  typedef struct packed {logic [8:0] d; logic [15:0] gap;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rom_data = rom_addr < 6'd4 ? rom[rom_addr[1:0]] : 9'h1FF;
  lcd_rom_sequencer #(
    .ADDR_W(6), .ROM_DEPTH(4), .POWERUP_CYCLES(20), .SETUP_CYCLES(2),
    .E_HIGH_CYCLES(EH), .CMD_WAIT_CYCLES(10), .CLEAR_WAIT_CYCLES(30)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask
  task tick;
    @(negedge clk);
    if (rst) last_rise = cyc;
    if (lcd_e && !prev_e) begin
      if (exp_q.size() == 0) check("e_unexpected", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("rs_db", 32'({lcd_rs, lcd_db}), 32'(e.d));
        if (e.gap != 16'd0) check("e_gap", cyc - last_rise, 32'(e.gap));
      end
      last_rise = cyc;
      held = {lcd_rs, lcd_db};
      hi_w = 1;
      check("rw_low", 32'(lcd_rw), 0);
    end else if (lcd_e) begin
      hi_w++;
      check("db_stable", 32'({lcd_rs, lcd_db}), 32'(held));
    end else if (prev_e && !rst) check("e_width", hi_w, EH);
    prev_e = lcd_e;
    if (done) begin
      if (!prev_done) begin
        done_cnt++;
        done_cyc = cyc;
        drun = 0;
      end
      drun++;
    end else if (prev_done) check("done_width", drun, 1);
    prev_done = done;
  endtask
  task set_rom(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c, input logic [8:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask
  task push(input logic [8:0] d, input int gap);
    exp_q.push_back({d, 16'(gap)});
  endtask
  task push_init;
    push(9'h038, 23); push(9'h00C, 16); push(9'h006, 16); push(9'h001, 16);
  endtask
  task pulse_start(output int edge_cyc);
    start = 1'b1;
    edge_cyc = cyc + 1;
    tick();
    start = 1'b0;
  endtask
  task finish_msg(input string tag, input int st, input int d_before, input int off);
    for (int i = 0; i < 400 && done_cnt == d_before; i++) tick();
    tick();
    check({tag, "_done_count"}, done_cnt - d_before, 1);
    check({tag, "_done_time"}, done_cyc - st, off);
    check({tag, "_addr_hold"}, 32'(rom_addr), 3);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask
  initial begin
    set_rom(9'h040, 9'h148, 9'h041, 9'h165);
    repeat (3) tick();
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_rs", 32'(lcd_rs), 0);
    check("rst_rw", 32'(lcd_rw), 0);
    check("rst_e", 32'(lcd_e), 0);
    check("rst_db", 32'(lcd_db), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_done", 32'(done), 0);
    push_init();
    rst = 1'b0;
    for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
    check("init_idle", 32'(busy), 0);
    check("init_clear_wait", cyc - last_rise, 33);
    check("init_q_empty", exp_q.size(), 0);
    push(9'h040, 0); push(9'h148, 16); push(9'h041, 16); push(9'h165, 16);
    d0 = done_cnt;
    pulse_start(s);
    finish_msg("msg", s, d0, 63);
    push(9'h040, 0); push(9'h148, 16); push(9'h041, 16); push(9'h165, 16);
    d0 = done_cnt;
    pulse_start(s);
    for (int i = 0; i < 100 && !(lcd_e && rom_addr == 6'd1); i++) tick();
    check("restart_ehigh_seen", 32'(lcd_e), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_msg("restart", s, d0, 63);
    set_rom(9'h001, 9'h148, 9'h041, 9'h165);
    push(9'h001, 0); push(9'h148, 36); push(9'h041, 16); push(9'h165, 16);
    d0 = done_cnt;
    pulse_start(s);
    finish_msg("clear", s, d0, 83);
    set_rom(9'h040, 9'h148, 9'h041, 9'h165);
    rst = 1'b1;
    repeat (2) tick();
    exp_q.delete();
    push_init();
    push(9'h040, 37); push(9'h148, 16); push(9'h041, 16); push(9'h165, 16);
    d0 = done_cnt;
    r = cyc;
    rst = 1'b0;
    repeat (4) tick();
    pulse_start(s);
    finish_msg("pending", r, d0, 168);
    push(9'h040, 0); push(9'h148, 16);
    d0 = done_cnt;
    pulse_start(s);
    for (int i = 0; i < 100 && !(lcd_e && rom_addr == 6'd1); i++) tick();
    check("abort_ehigh_seen", 32'(lcd_e), 1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_e", 32'(lcd_e), 0);
    check("abort_busy", 32'(busy), 1);
    check("abort_addr", 32'(rom_addr), 0);
    check("abort_rs", 32'(lcd_rs), 0);
    check("abort_db", 32'(lcd_db), 0);
    check("abort_done", 32'(done), 0);
    check("abort_q_empty", exp_q.size(), 0);
    exp_q.delete();
    push_init();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 300 && busy !== 1'b0; i++) tick();
    check("abort_reinit_idle", 32'(busy), 0);
    repeat (5) tick();
    check("abort_start_ignored", 32'(busy), 0);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
